// File: rtl/dfe_pkg.sv
// ---------------------------------------------------------------------------
// dfe_pkg : shared sample width, sample type and clog2 helper for DFE blocks
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dfe_pkg;

  localparam int DFE_DATA_WIDTH = 16;

  typedef logic signed [DFE_DATA_WIDTH-1:0] sample_t;

  function automatic int dfe_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dfe_fifo_core.sv
// ---------------------------------------------------------------------------
// dfe_fifo_core : first-word fall-through FIFO with registered head and level
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dfe_fifo_core
  import dfe_pkg::*;
#(
  parameter int DATA_WIDTH = DFE_DATA_WIDTH,
  parameter int DEPTH      = 16,
  localparam int AW        = dfe_clog2(DEPTH),
  localparam int LW        = AW + 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [LW-1:0]         level,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_ok, wr_ok;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign rd_ok   = rd && !empty;
  assign wr_ok   = wr && (!full || rd_ok);
  assign level   = level_q;
  assign rd_data = rd_data_q;

  always_comb begin
    wr_ptr_d  = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = rd_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d   = level_q;
    rd_data_d = rd_data_q;
    case ({wr_ok, rd_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    // Next head comes from the incoming word when it lands in the slot being
    // exposed; otherwise from storage. Hold the old head when going empty.
    if (level_d != '0) begin
      if (wr_ok && (wr_ptr_q == rd_ptr_d)) rd_data_d = wr_data;
      else                                 rd_data_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      rd_data_q <= rd_data_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dfe_out_fifo.sv
// ---------------------------------------------------------------------------
// dfe_out_fifo : elastic output buffer with drop counting and frame tagging
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dfe_out_fifo
  import dfe_pkg::*;
#(
  parameter int DATA_WIDTH = DFE_DATA_WIDTH,
  parameter int DEPTH      = 16,
  parameter int FRAME_LEN  = 64,
  parameter int CNT_WIDTH  = 16,
  localparam int LW        = dfe_clog2(DEPTH) + 1,
  localparam int FW        = (FRAME_LEN > 1) ? dfe_clog2(FRAME_LEN) : 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic [LW-1:0]         level,
  output logic                  overflow,
  output logic [CNT_WIDTH-1:0]  drop_cnt,
  input  logic                  clr_ovf
);

  logic                 full, empty, rd, wr, drop;
  logic                 overflow_q, overflow_d;
  logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic [FW-1:0]        frame_cnt_q, frame_cnt_d;

  dfe_fifo_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_core (
    .CLK     (CLK),
    .RST     (RST),
    .wr      (wr),
    .wr_data (in_data),
    .rd      (rd),
    .rd_data (out_data),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  assign out_valid = !empty;
  assign rd        = out_valid && out_ready;
  assign wr        = in_valid && (!full || rd);
  assign drop      = in_valid && full && !rd;
  assign out_last  = out_valid && (frame_cnt_q == FW'(FRAME_LEN - 1));
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

  always_comb begin
    overflow_d  = overflow_q;
    drop_cnt_d  = drop_cnt_q;
    frame_cnt_d = frame_cnt_q;
    // Clear beats a coincident drop for the count, but the flag still records it.
    if (clr_ovf) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
    end
    if (drop) overflow_d = 1'b1;
    if (rd) begin
      if (frame_cnt_q == FW'(FRAME_LEN - 1)) frame_cnt_d = '0;
      else                                    frame_cnt_d = frame_cnt_q + FW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dfe_out_fifo.sv
// ---------------------------------------------------------------------------
// tb_dfe_out_fifo : directed self-checking bench for dfe_out_fifo
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dfe_out_fifo;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic [4:0]  level;
  logic        overflow;
  logic [15:0] drop_cnt;
  logic        clr_ovf = 1'b0;

  int vectors = 0;
  int errors  = 0;

  dfe_out_fifo dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .level     (level),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt),
    .clr_ovf   (clr_ovf)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
    RST       = 1'b0;
    step();
    RST = 1'b1;
  endtask

  task automatic test_reset();
    step();
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    vectors++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
    vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", overflow); end
    vectors++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
    vectors++; if (out_data !== 16'd0) begin errors++; $display("FAIL reset_data got %h want 0000", out_data); end
    vectors++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", out_last); end
    RST = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    in_valid = 1'b1; in_data = 16'h8001;
    step();
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", out_valid); end
    vectors++; if (out_data !== 16'h8001) begin errors++; $display("FAIL single_data got %h want 8001", out_data); end
    vectors++; if (level !== 5'd1) begin errors++; $display("FAIL single_level got %0d want 1", level); end
    vectors++; if (out_last !== 1'b0) begin errors++; $display("FAIL single_last got %b want 0", out_last); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    vectors++; if (out_valid !== 1'b0 || level !== 5'd0) begin errors++; $display("FAIL single_drain got v=%b l=%0d want v=0 l=0", out_valid, level); end
    vectors++; if (out_data !== 16'h8001) begin errors++; $display("FAIL single_hold got %h want 8001", out_data); end
  endtask

  task automatic test_stream();
    int idx = 0;
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 620; c++) begin
      in_valid = (c % 3 == 0) && (c / 3 < 200);
      in_data  = 16'(c / 3);
      step();
      vectors++; if (level > 5'd1) begin errors++; $display("FAIL stream_level cycle %0d got %0d want <=1", c, level); end
      if (out_valid) begin
        vectors++; if (out_data !== 16'(idx)) begin errors++; $display("FAIL stream_data got %0d want %0d", out_data, idx); end
        vectors++; if (out_last !== (idx % 64 == 63)) begin errors++; $display("FAIL stream_last sample %0d got %b want %b", idx, out_last, (idx % 64 == 63)); end
        idx++;
      end
    end
    in_valid = 1'b0;
    vectors++; if (idx != 200) begin errors++; $display("FAIL stream_count got %0d want 200", idx); end
    vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL stream_ovf got %b want 0", overflow); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_data = 16'(100 + i);
      step();
    end
    in_valid = 1'b0;
    vectors++; if (level !== 5'd16) begin errors++; $display("FAIL bp_level got %0d want 16", level); end
    vectors++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_ovf got %b want 1", overflow); end
    vectors++; if (drop_cnt !== 16'd4) begin errors++; $display("FAIL bp_drop got %0d want 4", drop_cnt); end
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      vectors++; if (out_valid !== 1'b1 || out_data !== 16'(100 + i)) begin errors++; $display("FAIL bp_drain[%0d] got v=%b d=%0d want v=1 d=%0d", i, out_valid, out_data, 100 + i); end
      step();
    end
    vectors++; if (out_valid !== 1'b0 || level !== 5'd0) begin errors++; $display("FAIL bp_empty got v=%b l=%0d want v=0 l=0", out_valid, level); end
    out_ready = 1'b0;
  endtask

  task automatic test_full_rdwr();
    logic [15:0] q[$];
    do_reset();
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 16'(200 + i); q.push_back(16'(200 + i));
      step();
    end
    vectors++; if (level !== 5'd16) begin errors++; $display("FAIL frw_fill got %0d want 16", level); end
    out_ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      in_data = 16'(300 + j);
      vectors++; if (out_data !== q[0]) begin errors++; $display("FAIL frw_head[%0d] got %0d want %0d", j, out_data, q[0]); end
      void'(q.pop_front());
      q.push_back(16'(300 + j));
      step();
      vectors++; if (level !== 5'd16 || drop_cnt !== 16'd0) begin errors++; $display("FAIL frw_level[%0d] got l=%0d d=%0d want l=16 d=0", j, level, drop_cnt); end
    end
    in_valid = 1'b0;
    for (int j = 0; j < 16; j++) begin
      vectors++; if (out_valid !== 1'b1 || out_data !== q[0]) begin errors++; $display("FAIL frw_drain[%0d] got %0d want %0d", j, out_data, q[0]); end
      void'(q.pop_front());
      step();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_clr_ovf();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1; in_data = 16'(i);
      step();
    end
    vectors++; if (overflow !== 1'b1 || drop_cnt !== 16'd1) begin errors++; $display("FAIL clr_pre got o=%b d=%0d want o=1 d=1", overflow, drop_cnt); end
    clr_ovf = 1'b1;
    step();
    vectors++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL clr_drop got %0d want 0", drop_cnt); end
    vectors++; if (overflow !== 1'b1) begin errors++; $display("FAIL clr_ovf_set got %b want 1", overflow); end
    in_valid = 1'b0;
    step();
    clr_ovf = 1'b0;
    vectors++; if (overflow !== 1'b0 || drop_cnt !== 16'd0) begin errors++; $display("FAIL clr_quiet got o=%b d=%0d want o=0 d=0", overflow, drop_cnt); end
    vectors++; if (level !== 5'd16 || out_data !== 16'd0) begin errors++; $display("FAIL clr_contents got l=%0d d=%0d want l=16 d=0", level, out_data); end
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      in_valid = (i < 63); in_data = 16'(i);
      step();
    end
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_data = 16'(500 + i);
      step();
    end
    in_valid = 1'b0;
    vectors++; if (level !== 5'd7 || out_last !== 1'b1) begin errors++; $display("FAIL ar_pre got l=%0d last=%b want l=7 last=1", level, out_last); end
    #2;
    RST = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0 || level !== 5'd0) begin errors++; $display("FAIL ar_async got v=%b l=%0d want v=0 l=0", out_valid, level); end
    vectors++; if (overflow !== 1'b0 || out_last !== 1'b0) begin errors++; $display("FAIL ar_flags got o=%b last=%b want 0 0", overflow, out_last); end
    #2;
    RST = 1'b1;
    step();
    in_valid = 1'b1; in_data = 16'h1234;
    step();
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1 || out_data !== 16'h1234 || level !== 5'd1) begin errors++; $display("FAIL ar_head got v=%b d=%h l=%0d want v=1 d=1234 l=1", out_valid, out_data, level); end
    vectors++; if (out_last !== 1'b0) begin errors++; $display("FAIL ar_frame got last=%b want 0", out_last); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_full_rdwr();
    test_clr_ovf();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dfe_out_fifo.md
Name: dfe_out_fifo

Overview:
Elastic output buffer directly downstream of the DFE top-level filter chain. It accepts the chain's 16-bit decimated samples, which arrive on a qualifying strobe roughly one clock in three at 18 MHz. It presents them to the consumer over a valid/ready handshake. It also tags frame boundaries and counts dropped samples, so that host-side capture and back-pressure never corrupt the filter pipeline.

Parameters:
DATA_WIDTH, 16, sample width (signed two's complement, passed through unchanged)
DEPTH, 16, FIFO entries; must be a power of two, at least 2
FRAME_LEN, 64, output samples per frame; out_last marks the final one; at least 1
CNT_WIDTH, 16, width of the dropped-sample counter

Ports:
CLK  in  1  system clock, 18 MHz, rising-edge
RST  in  1  asynchronous, active-low reset
in_data  in  DATA_WIDTH  sample from the filter chain
in_valid  in  1  in_data qualifier; no back-pressure toward the chain
out_data  out  DATA_WIDTH  head-of-FIFO sample
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts out_data this cycle
out_last  out  1  current head sample is the last of a frame
level  out  log2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  out  1  sticky flag: at least one sample was dropped
drop_cnt  out  CNT_WIDTH  count of dropped samples, saturating at all-ones
clr_ovf  in  1  synchronous clear of overflow and drop_cnt

Behaviour:
- Reset (RST=0, asynchronous assert, synchronous release):
  - out_valid=0, out_last=0, level=0, overflow=0, drop_cnt=0, out_data=0.
  - Read/write pointers and the frame counter are cleared.
  - Storage contents are don't-care.
- Reset mid-operation discards all buffered samples. After release the block behaves exactly as from power-up.
- Write condition: wr = in_valid && (level<DEPTH || rd). Read condition: rd = out_valid && out_ready.
- Simultaneous rd and wr when full: both happen; level stays DEPTH and no drop occurs.
- Drop condition: in_valid && level==DEPTH && !rd.
  - The sample is discarded and overflow is set.
  - drop_cnt increments unless it is already at all-ones, where it holds.
  - FIFO contents are unchanged.
- First-word fall-through, latency 1: a sample written at edge k appears on out_data with out_valid=1 after edge k, provided the FIFO was empty.
- out_data is taken from registered storage only; there is no combinational path from in_data to out_data.
- When out_valid=0, out_data holds its last value. Consumers must ignore it.
- Level update per edge:
  - +1 on wr without rd.
  - −1 on rd without wr.
  - Unchanged when both or neither occur.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty status comes from level, never from pointer equality alone.
- Frame counter:
  - Counts 0..FRAME_LEN-1 and advances only on rd.
  - Wraps to 0 after FRAME_LEN-1.
  - out_last = out_valid && (frame_cnt==FRAME_LEN-1).
  - With FRAME_LEN=1, out_last equals out_valid.
- clr_ovf: at the edge where it is sampled high, overflow←0 and drop_cnt←0.
  - If a drop occurs in the same cycle, clear wins for drop_cnt, which reads 0.
  - overflow is set, so the new loss is still flagged.
- Arithmetic: data passes through bit-exact with no rounding or saturation. Only the counters saturate or wrap as stated.
- No internal state machine beyond the counters. Control is fully determined by level, rd and wr.

Decomposition:
- Shared package dfe_pkg:
  - DATA_WIDTH default.
  - A clog2 function.
  - A sample typedef of signed DATA_WIDTH bits.
- One sub-module, dfe_fifo_core: storage array, pointers and level, with a wr/rd interface and full/empty outputs.
- dfe_out_fifo wraps the core with the drop logic, the overflow/drop counter and the frame counter/out_last.

Test Plan:
1. Reset then a single sample: in_valid pulse with in_data=16'h8001, out_ready=0. Required: out_valid=1 and out_data=16'h8001 on the next cycle; level=1, out_last=0.
2. Filter-rate streaming: in_valid one cycle in three, 200 samples ramping 0..199, out_ready=1. Required: outputs equal 0..199 in order, level never exceeds 1, out_last high on samples 63, 127 and 191, overflow=0.
3. Back-pressure: out_ready=0 while writing 20 samples, DEPTH=16. Required: level saturates at 16, overflow=1, drop_cnt=4. Raising out_ready then yields exactly the first 16 samples in order.
4. Full with simultaneous read and write: at level=16 assert out_ready=1 and in_valid=1 for 10 consecutive cycles. Required: level stays 16, drop_cnt unchanged, no sample gap.
5. clr_ovf: assert it coincident with a drop. Required: drop_cnt=0 and overflow=1 next cycle. A further clr_ovf with no drop leaves overflow=0.
6. Asynchronous reset mid-stream: assert RST=0 between clock edges with level=7. Required: out_valid, level, overflow and out_last go 0 immediately without waiting for an edge. The first sample after release returns as the new head, and the frame count restarts at 0.
